// File: rtl/class_assoc_search.sv
// Purpose : buffers one query hypervector and scores every class from class_hvec_gen by XNOR-popcount agreement.
// Latency : result_valid rises NUM_CLASSES*NUM_FRAMES+3 edges after the edge accepting the final query chunk.
// Backpressure: query_ready only in LOAD; result held in DONE until result_ready, no new query meanwhile.
//
// Ports:
//   clk, rst                                   clock, synchronous active-high reset
//   query_valid/query_ready/query_chunk        query chunk input, frame 0 first
//   frame_id/frame_index                       class/frame address to class_hvec_gen
//   class_vec_in                               combinational class word returned for that address
//   result_valid/result_ready                  result handshake
//   result_class/result_score                  winning class and its agreement count
//   busy                                       high while sweeping or draining
module class_assoc_search #(
   parameter int DI_PARALLEL_W_BITS = 64,
   parameter int NUM_CLASSES        = 8,
   parameter int NUM_FRAMES         = 3,
   parameter int CLASS_W            = 3,
   parameter int FRAME_W            = 2,
   parameter int SCORE_W            = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          query_valid,
   output logic                          query_ready,
   input  logic [DI_PARALLEL_W_BITS-1:0] query_chunk,
   output logic [CLASS_W-1:0]            frame_id,
   output logic [FRAME_W-1:0]            frame_index,
   input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
   output logic                          result_valid,
   input  logic                          result_ready,
   output logic [CLASS_W-1:0]            result_class,
   output logic [SCORE_W-1:0]            result_score,
   output logic                          busy
);

   localparam int PC_W = $clog2(DI_PARALLEL_W_BITS + 1);

   typedef enum logic [1:0] {
      S_LOAD   = 2'd0,
      S_SEARCH = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                        r_state;
   state_t                        w_next_state;

   logic [FRAME_W-1:0]            r_load_cnt;
   logic [DI_PARALLEL_W_BITS-1:0] r_qbuf [NUM_FRAMES];

   logic [CLASS_W-1:0]            r_cls;
   logic [FRAME_W-1:0]            r_frm;

   logic [PC_W-1:0]               r_pc_q;
   logic                          r_pc_vld;
   logic                          r_pc_last;
   logic [CLASS_W-1:0]            r_pc_cls;

   logic [SCORE_W-1:0]            r_acc;
   logic [SCORE_W-1:0]            r_best_score;
   logic [CLASS_W-1:0]            r_best_class;

   logic [1:0]                    r_drain_cnt;
   logic [CLASS_W-1:0]            r_result_class;
   logic [SCORE_W-1:0]            r_result_score;

   logic                          w_accept;
   logic                          w_last_load;
   logic                          w_last_frm;
   logic                          w_last_cls;
   logic                          w_drain_done;
   logic [PC_W-1:0]               w_pc;
   logic [SCORE_W-1:0]            w_sum;

   function automatic logic [PC_W-1:0] popcnt(input logic [DI_PARALLEL_W_BITS-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction

   assign w_accept     = query_valid && (r_state == S_LOAD);
   assign w_last_load  = w_accept && (r_load_cnt == FRAME_W'(NUM_FRAMES - 1));
   assign w_last_frm   = (r_frm == FRAME_W'(NUM_FRAMES - 1));
   assign w_last_cls   = (r_cls == CLASS_W'(NUM_CLASSES - 1));
   // Three drain cycles: flush pc_q, settle the accumulate stage, latch the result.
   assign w_drain_done = (r_drain_cnt == 2'd2);
   assign w_pc         = popcnt(~(r_qbuf[r_frm] ^ class_vec_in));
   assign w_sum        = r_acc + SCORE_W'(r_pc_q);

   assign query_ready  = (r_state == S_LOAD);
   assign result_valid = (r_state == S_DONE);
   assign busy         = (r_state == S_SEARCH) || (r_state == S_DRAIN);
   // Counters are parked at zero outside the sweep, so the addresses read 0 there.
   assign frame_id     = r_cls;
   assign frame_index  = r_frm;
   assign result_class = r_result_class;
   assign result_score = r_result_score;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_LOAD:   if (w_last_load)               w_next_state = S_SEARCH;
         S_SEARCH: if (w_last_frm && w_last_cls)  w_next_state = S_DRAIN;
         S_DRAIN:  if (w_drain_done)              w_next_state = S_DONE;
         S_DONE:   if (result_ready)              w_next_state = S_LOAD;
         default:                                 w_next_state = S_LOAD;
      endcase
   end

   // Query storage is pure data; it is always fully rewritten before a sweep.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_qbuf[r_load_cnt] <= query_chunk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_load_cnt     <= '0;
         r_cls          <= '0;
         r_frm          <= '0;
         r_pc_q         <= '0;
         r_pc_vld       <= 1'b0;
         r_pc_last      <= 1'b0;
         r_pc_cls       <= '0;
         r_acc          <= '0;
         r_best_score   <= '0;
         r_best_class   <= '0;
         r_drain_cnt    <= '0;
         r_result_class <= '0;
         r_result_score <= '0;
      end else begin
         // Load counter
         if (w_accept) begin
            r_load_cnt <= w_last_load ? '0 : r_load_cnt + 1'b1;
         end else if ((r_state == S_DONE) && result_ready) begin
            r_load_cnt <= '0;
         end

         // Address sweep: frame is the fast index, class the slow one.
         if (r_state == S_SEARCH) begin
            if (w_last_frm) begin
               r_frm <= '0;
               r_cls <= w_last_cls ? '0 : r_cls + 1'b1;
            end else begin
               r_frm <= r_frm + 1'b1;
            end
         end

         // Popcount stage, tagged with its frame position and class.
         r_pc_vld  <= (r_state == S_SEARCH);
         r_pc_q    <= w_pc;
         r_pc_last <= w_last_frm;
         r_pc_cls  <= r_cls;

         // Accumulate stage
         if (w_last_load) begin
            r_acc        <= '0;
            r_best_score <= '0;
            r_best_class <= '0;
         end else if (r_pc_vld) begin
            if (!r_pc_last) begin
               r_acc <= w_sum;
            end else begin
               r_acc <= '0;
               // Strictly greater: ties keep the earlier (lower) class.
               if (w_sum > r_best_score) begin
                  r_best_score <= w_sum;
                  r_best_class <= r_pc_cls;
               end
            end
         end

         if (r_state == S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
         end else begin
            r_drain_cnt <= '0;
         end

         if ((r_state == S_DRAIN) && w_drain_done) begin
            r_result_class <= r_best_class;
            r_result_score <= r_best_score;
         end
      end
   end

endmodule

// File: tb/tb_class_assoc_search.sv
module tb_class_assoc_search;

   logic        clk = 1'b0;
   logic        rst;
   logic        query_valid;
   logic        query_ready;
   logic [63:0] query_chunk;
   logic [2:0]  frame_id;
   logic [1:0]  frame_index;
   logic [63:0] class_vec_in;
   logic        result_valid;
   logic        result_ready;
   logic [2:0]  result_class;
   logic [7:0]  result_score;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // ROM stub: 0 = class c has low 8c bits set, 1 = all zeros for every class,
   // 2 = class 5 returns the expected query chunk, other classes its inverse.
   int              stub_mode;
   logic [2:0][63:0] stub_q;

   typedef struct {
      int               mode;
      logic [2:0][63:0] c;
      logic [5:0]       pat;
      int               npat;
      int               hold;
      logic [2:0]       ecls;
      logic [7:0]       escore;
   } vec_t;

   vec_t vecs [4];

   class_assoc_search dut (
      .clk          (clk),
      .rst          (rst),
      .query_valid  (query_valid),
      .query_ready  (query_ready),
      .query_chunk  (query_chunk),
      .frame_id     (frame_id),
      .frame_index  (frame_index),
      .class_vec_in (class_vec_in),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .result_class (result_class),
      .result_score (result_score),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      class_vec_in = '0;
      case (stub_mode)
         0: for (int i = 0; i < 64; i++) class_vec_in[i] = (i < 8 * int'(frame_id));
         2: if (frame_index < 2'd3)
               class_vec_in = (frame_id == 3'd5) ? stub_q[frame_index] : ~stub_q[frame_index];
         default: class_vec_in = '0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Loads the query with the given valid pattern; returns at the final accept edge + #1.
   task automatic load_query(input vec_t v);
      int ci;
      ci = 0;
      stub_mode = v.mode;
      stub_q    = v.c;
      for (int i = 0; i < v.npat; i++) begin
         query_valid = v.pat[i];
         query_chunk = v.pat[i] ? v.c[ci] : 64'hDEAD_BEEF_DEAD_BEEF;
         tick();
         if (v.pat[i]) ci++;
      end
      query_valid = 1'b0;
      query_chunk = '0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int  n;
      bit  stable;
      load_query(v);
      chk({tag, "_busy_search"}, busy, 1);
      chk({tag, "_qrdy_search"}, query_ready, 0);
      n = 0;
      while (!result_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 27);
      chk({tag, "_class"}, result_class, v.ecls);
      chk({tag, "_score"}, result_score, v.escore);
      if (v.hold > 0) begin
         stable = 1'b1;
         for (int h = 0; h < v.hold; h++) begin
            tick();
            if (!result_valid || query_ready || result_class !== v.ecls || result_score !== v.escore)
               stable = 1'b0;
         end
         chk({tag, "_hold_stable"}, stable, 1);
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      chk({tag, "_rvld_after_accept"}, result_valid, 0);
      chk({tag, "_qrdy_after_accept"}, query_ready, 1);
      chk({tag, "_busy_idle"}, busy, 0);
      chk({tag, "_fid_idle"}, frame_id, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      bit   seen;
      vec_t z;

      vecs[0] = '{mode: 0, c: {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                  pat: 6'b000111, npat: 3, hold: 10, ecls: 3'd7, escore: 8'd168};
      vecs[1] = '{mode: 0, c: {64'h0, 64'h0, 64'h0},
                  pat: 6'b000111, npat: 3, hold: 0, ecls: 3'd0, escore: 8'd192};
      vecs[2] = '{mode: 1, c: {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                  pat: 6'b000111, npat: 3, hold: 0, ecls: 3'd0, escore: 8'd0};
      // c[0]=A, c[1]=B, c[2]=C; valid pattern 1,0,0,1,0,1
      vecs[3] = '{mode: 2, c: {64'hA5A5_5A5A_F00F_0FF0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                  pat: 6'b101001, npat: 6, hold: 2, ecls: 3'd5, escore: 8'd192};

      rst          = 1'b1;
      query_valid  = 1'b0;
      query_chunk  = '0;
      result_ready = 1'b0;
      stub_mode    = 0;
      stub_q       = '0;
      tick();
      tick();
      tick();
      rst = 1'b0;

      chk("rst_qrdy", query_ready, 1);
      chk("rst_rvld", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fid", frame_id, 0);
      chk("rst_fidx", frame_index, 0);
      chk("rst_rclass", result_class, 0);
      chk("rst_rscore", result_score, 0);

      for (int k = 0; k < 4; k++) begin
         run_vec(vecs[k], $sformatf("vec%0d", k));
      end

      // Reset in the middle of a sweep: the query is abandoned.
      z = vecs[1];
      load_query(z);
      for (int i = 0; i < 10; i++) tick();
      chk("mid_fid", frame_id, 3);
      chk("mid_fidx", frame_index, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_fid", frame_id, 0);
      chk("abort_fidx", frame_index, 0);
      chk("abort_qrdy", query_ready, 1);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (result_valid) seen = 1'b1;
         tick();
      end
      chk("abort_no_result", seen, 0);
      run_vec(z, "post_abort");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
